sum_output_queue: RTL
=====================

SUM_OUTPUT_QUEUE -- requirements
Module: sum_output_queue

Interface
REQ-001 Parameter WIDTH, default 32: data word width, matches the adding-machine result bus.
REQ-002 Parameter DEPTH, default 4: entry count; power of two, 2..16.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port in_data  input  WIDTH  running sum from the upstream adding machine.
REQ-006 Port in_valid  input  1  in_data is to be enqueued this cycle.
REQ-007 Port out_data  output  WIDTH  head-of-queue word.
REQ-008 Port out_valid  output  1  out_data holds a valid entry.
REQ-009 Port out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 Port full  output  1  count == DEPTH.
REQ-011 Port count  output  log2(DEPTH)+1  number of stored entries.
REQ-012 Port drop_count  output  16  words lost to overflow (present only per REQ-030).

Function
REQ-013 pop SHALL be out_valid && out_ready; pop when empty SHALL be impossible (out_valid=0).
REQ-014 push SHALL be in_valid && (!full || pop); a full queue SHALL accept a write in a cycle that also pops.
REQ-015 drop SHALL be in_valid && full && !pop; the dropped word SHALL be discarded, queue state unchanged.
REQ-016 count SHALL update as count + push - pop each cycle; push and pop together SHALL leave count unchanged.
REQ-017 Write and read pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH, no gap on wrap.
REQ-018 Ordering SHALL be strict FIFO; words leave in arrival order.
REQ-019 A word pushed in cycle N SHALL be visible on out_data no earlier than cycle N+1 (no combinational bypass).
REQ-020 out_valid SHALL be (count != 0), from registered state only.
REQ-021 out_data SHALL equal the entry at the read pointer when out_valid=1 and SHALL be all-zero when out_valid=0.
REQ-022 out_data and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 full SHALL be (count == DEPTH), from registered state only.
REQ-024 No arithmetic is performed on data; words pass bit-exact.

Reset
REQ-025 When reset=1 at a rising edge, read pointer, write pointer and count SHALL become 0.
REQ-026 After reset, out_valid=0, out_data=0, full=0, count=0, drop_count=0.
REQ-027 Reset SHALL take priority over simultaneous push/pop; in_valid during reset SHALL be ignored and not counted as a drop.
REQ-028 Storage array contents need not be reset; they are masked by REQ-021.
REQ-029 Reset asserted mid-stream SHALL discard all stored entries in that same edge.

Configuration
REQ-030 Macro SUM_QUEUE_DROP_COUNT_EN: when defined, drop_count port and a 16-bit counter SHALL exist, incrementing by 1 per drop cycle and saturating at 16'hFFFF.
REQ-031 When SUM_QUEUE_DROP_COUNT_EN is undefined, drop_count port and counter SHALL be absent; drops SHALL be silent; all other behaviour identical.

Verification
REQ-032 Reset, then in_valid=1 with in_data 1,3,6,10 on four cycles, out_ready=0 -> count=4, full=1, out_data=1 throughout, out_valid=1.
REQ-033 From REQ-032 state, out_ready=1, in_valid=0 for four cycles -> out_data 1,3,6,10 in order, then out_valid=0, out_data=0, count=0.
REQ-034 Full with head 1, in_valid=1 in_data=15 with out_ready=1 same cycle -> count stays 4, next outputs 3,6,10,15, drop_count unchanged.
REQ-035 Full, out_ready=0, in_valid=1 for 3 cycles with data 21,28,36 -> queue contents unchanged (1,3,6,10), drop_count=3 (macro on); saturation check: force 65540 drops -> drop_count=16'hFFFF.
REQ-036 Continuous in_valid=1 and out_ready=1 for 20 cycles with incrementing sums -> count never exceeds 1, pointers wrap cleanly, every word emitted exactly once, one cycle after entry.
REQ-037 Reset asserted with count=3 and in_valid=1 -> next cycle count=0, out_valid=0, out_data=0, drop_count=0.

Source files
------------

// File: rtl/sum_output_queue.sv
// Output FIFO for the adding-machine running sums: strict in-order, overflow drops the new word.
// Optional SUM_QUEUE_DROP_COUNT_EN adds a saturating 16-bit drop_count port.
module sum_output_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
`ifdef SUM_QUEUE_DROP_COUNT_EN
  ,
  output logic [15:0]              drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             push;
  logic             pop;
  logic             drop;

  // Status comes only from registered count, so a push is never bypassed to the output.
  assign out_valid = (cnt != '0);
  assign full      = (cnt == FULL_COUNT);
  assign count     = cnt;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // A full queue still accepts a word when the head leaves in the same cycle.
  assign pop  = out_valid & out_ready;
  assign push = in_valid & (~full | pop);
  assign drop = in_valid & full & ~pop;

  // NOTE: storage has no reset; stale entries are never visible because
  // out_data is masked to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of push/pop/cnt, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef SUM_QUEUE_DROP_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  // Drops are silent in this build; drop is kept only for symmetry with the counted build.
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule
